dcache_sa_ctrl: RTL
===================

// Module: dcache_sa_ctrl
// PURPOSE
//  Set-associative, write-back, write-allocate L1 data cache between the core (p1_*) and data memory (mem_*).
//  Next generation of the direct-mapped dcache_top:
//   - way count, set count and line size are parameters;
//   - per-byte write enables;
//   - round-robin victim selection that prefers invalid ways.
//  Tag/valid/dirty/data arrays are internal regs, read asynchronously.
// PARAMETERS
//  WAYS        2    associativity; legal values 1, 2, 4
//  SETS        32   sets per way; power of 2, >=2
//  LINE_BYTES  32   line size in bytes; power of 2, >=4; mem bus width = 8*LINE_BYTES
//  Derived: OFF_W=log2(LINE_BYTES), IDX_W=log2(SETS), TAG_W=32-IDX_W-OFF_W
// PORTS
//  clk_i          in   1             clock, rising edge
//  rst_i          in   1             reset, asynchronous, active-low
//  mem_data_i     in   8*LINE_BYTES  refill line from memory
//  mem_ack_i      in   1             memory done; single-cycle pulse
//  mem_data_o     out  8*LINE_BYTES  victim line for writeback
//  mem_addr_o     out  32            line address; low OFF_W bits are zero
//  mem_enable_o   out  1             memory request
//  mem_write_o    out  1             1 = writeback, 0 = refill read
//  p1_data_i      in   32            store data
//  p1_addr_i      in   32            byte address; bits [1:0] ignored (word access)
//  p1_be_i        in   4             store byte enables; bit n covers p1_data_i[8n+7:8n]
//  p1_MemRead_i   in   1             load request
//  p1_MemWrite_i  in   1             store request; takes priority if both are set
//  p1_data_o      out  32            load data
//  p1_stall_o     out  1             stall = req & ~hit (combinational)
// BEHAVIOUR
//  Address split: tag = [31:IDX_W+OFF_W], idx = [IDX_W+OFF_W-1:OFF_W], word = [OFF_W-1:2].
//  Lookup (combinational):
//   - hit = some way w with valid[w][idx] and tag[w][idx] == tag;
//   - at most one way can match; hw = index of the matching way;
//   - p1_data_o = selected 32-bit word of line[hw][idx] when hit, else 0.
//  Hit timing:
//   - load hit completes in the same cycle (stall=0);
//   - store hit: at the posedge, merge bytes enabled by p1_be_i into line[hw][idx] and set dirty[hw][idx].
//  States: IDLE, MISS, WRITEBACK, REFILL, REFILLOK.
//  IDLE
//   - req & ~hit -> MISS.
//  MISS (one cycle): latch victim v, idx and tag.
//   - v = lowest-numbered invalid way in the set; if none, v = rr[idx].
//   - valid[v] & dirty[v] -> WRITEBACK; drive mem_enable=1, mem_write=1,
//     mem_addr={tag[v][idx], idx, 0}, mem_data_o=line[v][idx].
//   - otherwise -> REFILL; drive mem_enable=1, mem_write=0, mem_addr={req tag, idx, 0}.
//  WRITEBACK: hold all mem outputs stable until mem_ack_i.
//   - On ack: dirty[v]=0, mem_write=0, mem_addr=refill address, mem_enable stays 1 -> REFILL.
//  REFILL: hold until mem_ack_i. On ack, in that cycle:
//   - line[v] = mem_data_i, tag[v] = req tag, valid=1, dirty=0;
//   - mem_enable=0;
//   - rr[idx] = (v+1) mod WAYS, only when v was taken from rr[idx];
//   - -> REFILLOK.
//  REFILLOK: -> IDLE.
//   - Lookup now hits; a store merges on the following hit cycle (write allocate).
//  Rules during a miss:
//   - mem_enable_o is never deasserted between WRITEBACK and REFILL;
//   - mem_ack_i outside WRITEBACK/REFILL is ignored;
//   - the core must hold p1_* stable while stalled;
//   - if the request drops, the refill still completes, then IDLE.
//  Reset, asynchronous:
//   - state=IDLE; mem_enable_o=0, mem_write_o=0, mem_addr_o=0;
//   - all valid/dirty=0; all rr=0;
//   - data/tag arrays are not cleared;
//   - reset mid-miss aborts the transaction; memory must tolerate the dropped enable.
//  WAYS=1: v is always 0; behaviour equals the direct-mapped cache.
// TESTING (defaults: tag=[31:10], idx=[9:5])
//  1. Reset, then read 0x040 -> stall; REFILL addr 0x040, write=0; ack with line whose word0 = 0xA5A5_0001
//     -> stall drops in REFILLOK+1; p1_data_o=0xA5A5_0001; re-read 0x040 hits with no stall.
//  2. Store 0x040 data 0x1122_3344 be=4'b0101 on a line holding 0xA5A5_0001
//     -> single-cycle hit; read back 0xA522_0044; dirty set.
//  3. Read 0x440 (same set 2) -> refill into way 1; 0x040 and 0x440 both hit afterwards; no writeback.
//  4. After tests 2-3, read 0x840 -> victim way 0 (rr=0) is dirty:
//     - WRITEBACK addr 0x040, write=1, data carries 0xA522_0044;
//     - ack -> REFILL addr 0x840 with no enable gap;
//     - after the refill, rr[2]=1 and a read of 0x040 misses.
//  5. Drop rst_i during REFILL -> outputs 0 immediately; state IDLE; a read of 0x440 misses.
//  6. WAYS=1, LINE_BYTES=16: alternate 0x000 / 0x200 (same set)
//     -> every access misses; a store makes the next eviction a writeback.

Source files
------------

// File: rtl/dcache_sa_ctrl.sv
// dcache_sa_ctrl: set-associative write-back/write-allocate L1 data cache controller with round-robin victim choice.
module dcache_sa_ctrl #(
  parameter int WAYS       = 2,
  parameter int SETS       = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [8*LINE_BYTES-1:0] mem_data_i,
  input  logic                    mem_ack_i,
  output logic [8*LINE_BYTES-1:0] mem_data_o,
  output logic [31:0]             mem_addr_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  input  logic [31:0]             p1_data_i,
  input  logic [31:0]             p1_addr_i,
  input  logic [3:0]              p1_be_i,
  input  logic                    p1_MemRead_i,
  input  logic                    p1_MemWrite_i,
  output logic [31:0]             p1_data_o,
  output logic                    p1_stall_o
);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int LW    = 8 * LINE_BYTES;
  localparam int WW    = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, REFILL, REFILLOK} state_t;
  state_t state;
  logic [LW-1:0]    line_arr [WAYS][SETS];
  logic [TAG_W-1:0] tag_arr  [WAYS][SETS];
  logic             valid_q  [WAYS][SETS];
  logic             dirty_q  [WAYS][SETS];
  logic [WW-1:0]    rr_q     [SETS];
  logic [WW-1:0]    v_q;
  logic [IDX_W-1:0] vidx_q;
  logic [TAG_W-1:0] vtag_q;
  logic             vrr_q;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] boff;
  logic [OFF_W+2:0] sh;
  logic [LW-1:0]    wmask, wdata;
  logic [WW-1:0]    hw, vic;
  logic             hit, vic_rr, req, st_hit, refill_ack;
  assign tag   = p1_addr_i[31:IDX_W+OFF_W];
  assign idx   = p1_addr_i[IDX_W+OFF_W-1:OFF_W];
  assign boff  = p1_addr_i[OFF_W-1:0] & ~OFF_W'(3);
  assign sh    = {boff, 3'b000};
  assign req   = p1_MemRead_i | p1_MemWrite_i;
  assign wmask = LW'({{8{p1_be_i[3]}}, {8{p1_be_i[2]}}, {8{p1_be_i[1]}}, {8{p1_be_i[0]}}}) << sh;
  assign wdata = LW'(p1_data_i) << sh;
  always_comb begin
    hit = 1'b0;
    hw  = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[w][idx] && tag_arr[w][idx] == tag) begin
        hit = 1'b1;
        hw  = WW'(w);
      end
  end
  // lowest invalid way wins; round robin only when the set is full
  always_comb begin
    vic    = rr_q[idx];
    vic_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid_q[w][idx]) begin
        vic    = WW'(w);
        vic_rr = 1'b0;
      end
  end
  assign p1_data_o  = hit ? 32'(line_arr[hw][idx] >> sh) : '0;
  // hits are only served from IDLE so a post-refill store still merges on its own cycle
  assign p1_stall_o = req & ~(hit & (state == IDLE));
  assign st_hit     = (state == IDLE) & hit & p1_MemWrite_i;
  assign refill_ack = (state == REFILL) & mem_ack_i;
  always_ff @(posedge clk_i) begin
    if (st_hit) line_arr[hw][idx] <= (line_arr[hw][idx] & ~wmask) | (wdata & wmask);
    if (refill_ack) begin
      line_arr[v_q][vidx_q] <= mem_data_i;
      tag_arr[v_q][vidx_q]  <= vtag_q;
    end
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      v_q          <= '0;
      vidx_q       <= '0;
      vtag_q       <= '0;
      vrr_q        <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
        end
      end
    end else begin
      if (st_hit) dirty_q[hw][idx] <= 1'b1;
      case (state)
        IDLE: if (req && !hit) state <= MISS;
        MISS: begin
          v_q          <= vic;
          vidx_q       <= idx;
          vtag_q       <= tag;
          vrr_q        <= vic_rr;
          mem_enable_o <= 1'b1;
          if (valid_q[vic][idx] && dirty_q[vic][idx]) begin
            state       <= WRITEBACK;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_arr[vic][idx], idx, {OFF_W{1'b0}}};
            mem_data_o  <= line_arr[vic][idx];
          end else begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag, idx, {OFF_W{1'b0}}};
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          dirty_q[v_q][vidx_q] <= 1'b0;
          mem_write_o          <= 1'b0;
          mem_addr_o           <= {vtag_q, vidx_q, {OFF_W{1'b0}}};
          state                <= REFILL;
        end
        REFILL: if (mem_ack_i) begin
          valid_q[v_q][vidx_q] <= 1'b1;
          dirty_q[v_q][vidx_q] <= 1'b0;
          mem_enable_o         <= 1'b0;
          if (vrr_q) rr_q[vidx_q] <= WW'((int'(v_q) + 1) % WAYS);
          state <= REFILLOK;
        end
        REFILLOK: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end
endmodule
